// File: rtl/jk_cmd_driver.sv
// Purpose: queues hold/reset/set/toggle commands and replays each on a JK flip-flop's j/k for cmd_rpt+1 cycles,
//          checking the flop's q against a shadow model and flagging any divergence in a sticky mismatch bit.
// Latency/backpressure: an accepted command reaches j/k one edge after acceptance (when idle); cmd_ready drops while the FIFO is full.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_op = {j,k}, cmd_rpt = repeat count minus one
//   j, k                    registered drive to the flip-flop
//   q_fb                    flip-flop output fed back
//   exp_q, mismatch         shadow-model prediction and sticky divergence flag
//   busy, level             DRIVE-state indicator and FIFO occupancy
module jk_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_rpt,
    output logic                     j,
    output logic                     k,
    input  logic                     q_fb,
    output logic                     exp_q,
    output logic                     mismatch,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [1:0]       op;
        logic [CNT_W-1:0] rpt;
    } cmd_t;

    typedef enum logic {IDLE, DRIVE} state_t;

    cmd_t             mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    cmd_t             head;

    state_t           state_q;
    state_t           state_d;
    // The registered {j,k} doubles as the current op while in DRIVE.
    logic [1:0]       jk_q;
    logic [1:0]       jk_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign cmd_ready = !reset && !full;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];

    assign j    = jk_q[1];
    assign k    = jk_q[0];
    assign busy = (state_q == DRIVE);

    // Next-state / pop decision. The pop only looks at registered occupancy,
    // so a command pushed on this edge is popped no earlier than the next one.
    always_comb begin
        state_d = state_q;
        jk_d    = jk_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                jk_d = 2'b00;
                if (!empty) begin
                    pop     = 1'b1;
                    jk_d    = head.op;
                    cnt_d   = head.rpt;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!empty) begin
                    // Chain straight into the next command with no idle gap.
                    pop   = 1'b1;
                    jk_d  = head.op;
                    cnt_d = head.rpt;
                end else begin
                    jk_d    = 2'b00;
                    state_d = IDLE;
                end
            end
            default: begin
                jk_d    = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd_op, rpt: cmd_rpt};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            jk_q     <= 2'b00;
            cnt_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            exp_q    <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            state_q <= state_d;
            jk_q    <= jk_d;
            cnt_q   <= cnt_d;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // Shadow model advances from the same j/k the flop sees this edge.
            case (jk_q)
                2'b01:   exp_q <= 1'b0;
                2'b10:   exp_q <= 1'b1;
                2'b11:   exp_q <= ~exp_q;
                default: exp_q <= exp_q;
            endcase
            if (q_fb != exp_q) mismatch <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jk_cmd_driver.sv
module tb_jk_cmd_driver;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_rpt = '0;
    logic             j;
    logic             k;
    logic             q_fb;
    logic             exp_q;
    logic             mismatch;
    logic             busy;
    logic [2:0]       level;

    logic             ff_q;
    logic             inject = 1'b0;
    int               n_cmp = 0;
    int               n_fail = 0;

    jk_cmd_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rpt(cmd_rpt), .j(j), .k(k), .q_fb(q_fb),
        .exp_q(exp_q), .mismatch(mismatch), .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    // Behavioural JK flip-flop standing in for the downstream stage.
    always @(posedge clk) begin
        if (reset) ff_q <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end
    assign q_fb = inject ? 1'b0 : ff_q;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cmd_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_reset got=%b want=0", cmd_ready); end
        n_cmp++; if ({j, k} !== 2'b00) begin n_fail++; $display("FAIL reset_jk got=%b want=00", {j, k}); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        reset = 1'b0;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got=%b want=1", cmd_ready); end
        n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d want=0", level); end
        n_cmp++; if (exp_q !== 1'b0) begin n_fail++; $display("FAIL reset_exp_q got=%b want=0", exp_q); end
        n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mismatch got=%b want=0", mismatch); end
    endtask

    task automatic test_set_toggle;
        logic [9:0] jk_seq;
        logic [4:0] busy_seq;
        logic [4:0] q_seq;
        jk_seq   = 10'b10_11_11_11_00;
        busy_seq = 5'b11110;
        q_seq    = 5'b01010;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rpt = 4'd0;
        tick();
        n_cmp++; if ({j, k} !== 2'b00) begin n_fail++; $display("FAIL st_not_yet_driven got=%b want=00", {j, k}); end
        n_cmp++; if (level !== 3'd1) begin n_fail++; $display("FAIL st_level1 got=%0d want=1", level); end
        cmd_op = 2'b11; cmd_rpt = 4'd2;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({j, k} !== jk_seq[9-2*i -: 2]) begin n_fail++; $display("FAIL st_jk[%0d] got=%b want=%b", i, {j, k}, jk_seq[9-2*i -: 2]); end
            n_cmp++; if (busy !== busy_seq[4-i]) begin n_fail++; $display("FAIL st_busy[%0d] got=%b want=%b", i, busy, busy_seq[4-i]); end
            n_cmp++; if (exp_q !== q_seq[4-i]) begin n_fail++; $display("FAIL st_exp_q[%0d] got=%b want=%b", i, exp_q, q_seq[4-i]); end
            tick();
        end
        n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL st_mismatch got=%b want=0", mismatch); end
    endtask

    task automatic test_fifo_full;
        logic [1:0] ops [6];
        int n;
        ops[0] = 2'b10; ops[1] = 2'b01; ops[2] = 2'b11;
        ops[3] = 2'b10; ops[4] = 2'b01; ops[5] = 2'b11;
        cmd_rpt = 4'd15;
        for (int i = 0; i < 5; i++) begin
            cmd_op = ops[i]; cmd_valid = 1'b1;
            n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ff_ready_push%0d got=%b want=1", i, cmd_ready); end
            tick();
            if (i == 1) begin
                n_cmp++; if ({j, k} !== ops[0]) begin n_fail++; $display("FAIL ff_first_op got=%b want=%b", {j, k}, ops[0]); end
            end
        end
        n_cmp++; if (level !== 3'd4) begin n_fail++; $display("FAIL ff_level_full got=%0d want=4", level); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ff_ready_full got=%b want=0", cmd_ready); end
        cmd_op = ops[5];
        n = 0;
        while (!cmd_ready && n < 40) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== 13) begin n_fail++; $display("FAIL ff_stall_cycles got=%0d want=13", n); end
        n_cmp++; if ({j, k} !== ops[1]) begin n_fail++; $display("FAIL ff_op1 got=%b want=%b", {j, k}, ops[1]); end
        n_cmp++; if (level !== 3'd3) begin n_fail++; $display("FAIL ff_level_after_pop got=%0d want=3", level); end
        tick();
        cmd_valid = 1'b0;
        n_cmp++; if (level !== 3'd4) begin n_fail++; $display("FAIL ff_level_refill got=%0d want=4", level); end
        repeat (15) tick();
        for (int i = 2; i < 6; i++) begin
            n_cmp++; if ({j, k} !== ops[i]) begin n_fail++; $display("FAIL ff_op%0d got=%b want=%b", i, {j, k}, ops[i]); end
            repeat (16) tick();
        end
        n_cmp++; if ({j, k} !== 2'b00) begin n_fail++; $display("FAIL ff_drain_jk got=%b want=00", {j, k}); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ff_drain_busy got=%b want=0", busy); end
        n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL ff_drain_level got=%0d want=0", level); end
        n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL ff_mismatch got=%b want=0", mismatch); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] jk_seq;
        logic [4:0] busy_seq;
        jk_seq   = 10'b01_01_10_10_00;
        busy_seq = 5'b11110;
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rpt = 4'd3;
        tick();
        cmd_op = 2'b01; cmd_rpt = 4'd1;
        tick();
        n_cmp++; if ({j, k} !== 2'b11) begin n_fail++; $display("FAIL b2b_lead_start got=%b want=11", {j, k}); end
        cmd_op = 2'b10; cmd_rpt = 4'd1;
        tick();
        cmd_valid = 1'b0;
        n_cmp++; if (level !== 3'd2) begin n_fail++; $display("FAIL b2b_level got=%0d want=2", level); end
        tick();
        tick();
        n_cmp++; if ({j, k} !== 2'b11) begin n_fail++; $display("FAIL b2b_lead_end got=%b want=11", {j, k}); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if ({j, k} !== jk_seq[9-2*i -: 2]) begin n_fail++; $display("FAIL b2b_jk[%0d] got=%b want=%b", i, {j, k}, jk_seq[9-2*i -: 2]); end
            n_cmp++; if (busy !== busy_seq[4-i]) begin n_fail++; $display("FAIL b2b_busy[%0d] got=%b want=%b", i, busy, busy_seq[4-i]); end
        end
    endtask

    task automatic test_fault;
        n_cmp++; if (exp_q !== 1'b1) begin n_fail++; $display("FAIL flt_pre_exp_q got=%b want=1", exp_q); end
        inject = 1'b1;
        #1;
        n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL flt_before_edge got=%b want=0", mismatch); end
        tick();
        inject = 1'b0;
        n_cmp++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL flt_raised got=%b want=1", mismatch); end
        tick();
        tick();
        n_cmp++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL flt_sticky got=%b want=1", mismatch); end
        reset = 1'b1;
        tick();
        n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL flt_cleared got=%b want=0", mismatch); end
        n_cmp++; if (exp_q !== 1'b0) begin n_fail++; $display("FAIL flt_exp_q_reset got=%b want=0", exp_q); end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid;
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rpt = 4'd7;
        tick();
        cmd_op = 2'b01; cmd_rpt = 4'd3;
        tick();
        cmd_op = 2'b10; cmd_rpt = 4'd3;
        tick();
        cmd_valid = 1'b0;
        n_cmp++; if (level !== 3'd2) begin n_fail++; $display("FAIL rm_level_queued got=%0d want=2", level); end
        tick();
        n_cmp++; if ({j, k} !== 2'b11) begin n_fail++; $display("FAIL rm_cycle3_jk got=%b want=11", {j, k}); end
        reset = 1'b1;
        tick();
        n_cmp++; if ({j, k} !== 2'b00) begin n_fail++; $display("FAIL rm_jk got=%b want=00", {j, k}); end
        n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL rm_level got=%0d want=0", level); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got=%b want=0", busy); end
        n_cmp++; if (exp_q !== 1'b0) begin n_fail++; $display("FAIL rm_exp_q got=%b want=0", exp_q); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready got=%b want=0", cmd_ready); end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if ({j, k} !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_no_resume[%0d] jk=%b busy=%b want jk=00 busy=0", i, {j, k}, busy); end
        end
        n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL rm_level_after got=%0d want=0", level); end
        n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL rm_mismatch got=%b want=0", mismatch); end
    endtask

    initial begin
        test_reset();
        test_set_toggle();
        test_fifo_full();
        test_back_to_back();
        test_fault();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
